// File: rtl/types_pkg.sv
// Shared state encodings for the keystream generator and the stream XOR datapath.
package types_pkg;

  typedef enum logic [1:0] {
    HG_IDLE   = 2'd0,
    HG_LOAD   = 2'd1,
    HG_HASH   = 2'd2,
    HG_OUTPUT = 2'd3
  } hash_generator_state_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQUEST  = 2'd1,
    S_WAIT_KEY = 2'd2,
    S_OUTPUT   = 2'd3
  } stream_xor_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with power-of-two depth, naturally wrapping pointers and a flush.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push & ~full & ~flush;
  assign w_pop  = pop & ~empty & ~flush;
  assign dout   = r_mem[r_rd_ptr];
  assign count  = r_count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/stream_xor_unit.sv
// Byte-serial stream-cipher XOR stage: buffers bytes, requests one keystream byte each, emits data ^ key.
// Optional keystream-wait timeout and re-request is enabled by defining STREAM_XOR_TIMEOUT_EN.
module stream_xor_unit
  import types_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          clear,
  input  logic [7:0]                    in_byte,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [7:0]                    out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          request_hash_byte_pulse,
  input  logic [7:0]                    hash_byte,
  input  logic                          hash_byte_pulse,
  output logic                          reset_hash,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          timeout_err,
  output logic [1:0]                    dbg_state
);

  // Handshakes: a byte moves on in_valid & in_ready and on out_valid & out_ready at the rising
  // edge; out_byte/out_valid hold steady while out_ready is low.

  stream_xor_state_t                 r_state;
  stream_xor_state_t                 w_next_state;
  logic [7:0]                        r_out_byte;
  logic                              r_out_valid;
  logic                              r_reset_hash;
  logic                              w_full;
  logic                              w_empty;
  logic [7:0]                        w_head;
  logic [$clog2(FIFO_DEPTH):0]       w_count;
  logic                              w_push;
  logic                              w_capture;
  logic                              w_timeout;

  assign w_push    = in_valid & in_ready & ~clear;
  assign w_capture = (r_state == S_WAIT_KEY) & hash_byte_pulse;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .flush (clear),
    .push  (w_push),
    .din   (in_byte),
    .pop   (w_capture),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign in_ready                = ~w_full;
  assign out_byte                = r_out_byte;
  assign out_valid               = r_out_valid;
  assign reset_hash              = r_reset_hash;
  assign fifo_count              = w_count;
  assign request_hash_byte_pulse = (r_state == S_REQUEST);
  assign busy                    = (r_state != S_IDLE) | ~w_empty;
  assign dbg_state               = r_state;

`ifdef STREAM_XOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_wait_cnt;
  logic          r_timeout_err;

  // Counter sits at zero outside S_WAIT_KEY, so every entry into the wait starts fresh.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                      r_wait_cnt <= '0;
    else if (r_state != S_WAIT_KEY) r_wait_cnt <= '0;
    else                            r_wait_cnt <= r_wait_cnt + TW'(1);
  end

  assign w_timeout = (r_state == S_WAIT_KEY) & ~hash_byte_pulse &
                     (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)          r_timeout_err <= 1'b0;
    else if (clear)     r_timeout_err <= 1'b0;
    else if (w_timeout) r_timeout_err <= 1'b1;
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_count != '0) w_next_state = S_REQUEST;
      S_REQUEST:  w_next_state = S_WAIT_KEY;
      S_WAIT_KEY: begin
        if (hash_byte_pulse) w_next_state = S_OUTPUT;
        else if (w_timeout)  w_next_state = S_REQUEST;
      end
      S_OUTPUT:   if (out_ready) w_next_state = (w_count != '0) ? S_REQUEST : S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
    if (clear) w_next_state = S_IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_out_byte   <= 8'h00;
      r_out_valid  <= 1'b0;
      r_reset_hash <= 1'b0;
    end else begin
      r_reset_hash <= clear;
      if (clear) begin
        r_out_valid <= 1'b0;
      end else if (w_capture) begin
        r_out_byte  <= w_head ^ hash_byte;
        r_out_valid <= 1'b1;
      end else if ((r_state == S_OUTPUT) && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_xor_unit.sv
// Directed bench for stream_xor_unit with a cycle-stepped keystream generator model.
module tb_stream_xor_unit;
  import types_pkg::*;

  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic       clk = 1'b0;
  logic       nrst;
  logic       clear;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic       request_hash_byte_pulse;
  logic [7:0] hash_byte;
  logic       hash_byte_pulse;
  logic       reset_hash;
  logic       busy;
  logic [2:0] fifo_count;
  logic       timeout_err;
  logic [1:0] dbg_state;

  stream_xor_unit #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk                     (clk),
    .nrst                    (nrst),
    .clear                   (clear),
    .in_byte                 (in_byte),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .out_byte                (out_byte),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .request_hash_byte_pulse (request_hash_byte_pulse),
    .hash_byte               (hash_byte),
    .hash_byte_pulse         (hash_byte_pulse),
    .reset_hash              (reset_hash),
    .busy                    (busy),
    .fifo_count              (fifo_count),
    .timeout_err             (timeout_err),
    .dbg_state               (dbg_state)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_req = 0;
  int         n_rsth = 0;
  int         kidx = 0;
  int         gen_cd = 0;
  bit         gen_en = 1'b0;
  bit         man_pulse = 1'b0;
  logic [7:0] man_key = 8'h00;
  logic [7:0] keys [16];
  logic [7:0] exp_q [$];

  // One clock step; inputs change 1 time unit after the edge, and the generator model
  // answers each request with the next keystream byte two cycles later.
  task automatic tick();
    @(posedge clk);
    #1;
    hash_byte_pulse = 1'b0;
    if (reset_hash) begin
      kidx = 0;
      n_rsth++;
    end
    if (gen_cd > 0) begin
      gen_cd--;
      if (gen_cd == 0) begin
        hash_byte_pulse = 1'b1;
        hash_byte       = keys[kidx % 16];
        kidx++;
      end
    end
    if (man_pulse) begin
      hash_byte_pulse = 1'b1;
      hash_byte       = man_key;
      man_pulse       = 1'b0;
    end
    if (request_hash_byte_pulse) begin
      n_req++;
      if (gen_en) gen_cd = 2;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic run_stream(input logic [7:0] din [16], output logic [7:0] dout [16],
                            output int got);
    int  idx;
    bit  acc;
    idx = 0;
    got = 0;
    for (int c = 0; c < 400 && got < 16; c++) begin
      in_valid = (idx < 16);
      in_byte  = (idx < 16) ? din[idx] : 8'h00;
      acc      = in_valid && in_ready;
      if (out_valid) begin
        dout[got] = out_byte;
        got++;
      end
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    tick();
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_byte !== 8'h00) begin n_bad++; $display("FAIL reset_out_byte: got %h want 00", out_byte); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    n_cmp++;
    if ({out_valid, request_hash_byte_pulse, reset_hash, busy, timeout_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000",
               {out_valid, request_hash_byte_pulse, reset_hash, busy, timeout_err});
    end
    n_cmp++; if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int lat;
    int req0;
    do_clear();
    gen_en = 1'b1;
    out_ready = 1'b1;
    req0 = n_req;
    push_byte(8'h41);
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL single_latency: got %0d want 4", lat); end
    n_cmp++; if (out_byte !== 8'h1B) begin n_bad++; $display("FAIL single_out_byte: got %h want 1b", out_byte); end
    n_cmp++; if (n_req - req0 !== 1) begin n_bad++; $display("FAIL single_requests: got %0d want 1", n_req - req0); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_drop: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_fill();
    logic [7:0] d [5];
    logic [7:0] e;
    bit         acc;
    int         got;
    d = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
    do_clear();
    gen_en = 1'b1;
    out_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) push_byte(d[i]);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL fill_count: got %0d want 4", fifo_count); end
    in_valid = 1'b1;
    in_byte  = d[4];
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      if (in_ready) acc = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL fill_fifth_push: got %b want 1", acc); end
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL fill_count_after5: got %0d want 4", fifo_count); end
    for (int i = 0; i < 5; i++) exp_q.push_back(d[i] ^ keys[i]);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 200 && got < 5; c++) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (out_byte !== e) begin n_bad++; $display("FAIL fill_drain[%0d]: got %h want %h", got, out_byte, e); end
        got++;
      end
      tick();
    end
    n_cmp++; if (got !== 5) begin n_bad++; $display("FAIL fill_drain_count: got %0d want 5", got); end
  endtask

  task automatic test_backpressure();
    int         k;
    int         req0;
    int         bad;
    logic [7:0] held;
    do_clear();
    gen_en = 1'b1;
    out_ready = 1'b0;
    req0 = n_req;
    push_byte(8'h66);
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    n_cmp++; if (out_byte !== 8'h3C) begin n_bad++; $display("FAIL bp_out_byte: got %h want 3c", out_byte); end
    held = out_byte;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_byte !== held) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
    n_cmp++; if (n_req - req0 !== 1) begin n_bad++; $display("FAIL bp_requests: got %0d want 1", n_req - req0); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got %b want 0", out_valid); end
  endtask

  task automatic test_clear();
    int req0;
    int rs0;
    do_clear();
    gen_en = 1'b0;
    out_ready = 1'b0;
    req0 = n_req;
    rs0 = n_rsth;
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    tick();
    tick();
    n_cmp++; if (dbg_state !== S_WAIT_KEY) begin n_bad++; $display("FAIL clear_pre_state: got %0d want %0d", dbg_state, S_WAIT_KEY); end
    n_cmp++; if (fifo_count !== 3'd3) begin n_bad++; $display("FAIL clear_pre_count: got %0d want 3", fifo_count); end
    clear = 1'b1;
    in_valid = 1'b1;
    in_byte = 8'hA4;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL clear_count: got %0d want 0", fifo_count); end
    n_cmp++; if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL clear_state: got %0d want %0d", dbg_state, S_IDLE); end
    n_cmp++; if (reset_hash !== 1'b1) begin n_bad++; $display("FAIL clear_reset_hash_hi: got %b want 1", reset_hash); end
    tick();
    n_cmp++; if (reset_hash !== 1'b0) begin n_bad++; $display("FAIL clear_reset_hash_lo: got %b want 0", reset_hash); end
    n_cmp++; if (n_rsth - rs0 !== 1) begin n_bad++; $display("FAIL clear_reset_hash_len: got %0d want 1", n_rsth - rs0); end
    man_key = 8'h77;
    man_pulse = 1'b1;
    tick();
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clear_stray_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clear_stray_busy: got %b want 0", busy); end
    n_cmp++; if (n_req - req0 !== 1) begin n_bad++; $display("FAIL clear_requests: got %0d want 1", n_req - req0); end
  endtask

  task automatic test_timeout();
    int k;
    int req0;
    do_clear();
    gen_en = 1'b0;
    out_ready = 1'b1;
    req0 = n_req;
    push_byte(8'h00);
`ifdef STREAM_XOR_TIMEOUT_EN
    k = 0;
    while (n_req == req0 && k < 10) begin tick(); k++; end
    k = 0;
    while (!timeout_err && k < 30) begin tick(); k++; end
    n_cmp++; if (k !== TO + 1) begin n_bad++; $display("FAIL to_delay: got %0d want %0d", k, TO + 1); end
    n_cmp++; if (request_hash_byte_pulse !== 1'b1) begin n_bad++; $display("FAIL to_rerequest: got %b want 1", request_hash_byte_pulse); end
    n_cmp++; if (n_req - req0 !== 2) begin n_bad++; $display("FAIL to_requests: got %0d want 2", n_req - req0); end
    tick();
    man_key = 8'hFF;
    man_pulse = 1'b1;
    k = 0;
    while (!out_valid && k < 10) begin tick(); k++; end
    n_cmp++; if (out_byte !== 8'hFF) begin n_bad++; $display("FAIL to_late_byte: got %h want ff", out_byte); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    do_clear();
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_clear: got %b want 0", timeout_err); end
`else
    for (int i = 0; i < 30; i++) tick();
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL wait_no_err: got %b want 0", timeout_err); end
    n_cmp++; if (dbg_state !== S_WAIT_KEY) begin n_bad++; $display("FAIL wait_state: got %0d want %0d", dbg_state, S_WAIT_KEY); end
    n_cmp++; if (n_req - req0 !== 1) begin n_bad++; $display("FAIL wait_requests: got %0d want 1", n_req - req0); end
    man_key = 8'hFF;
    man_pulse = 1'b1;
    k = 0;
    while (!out_valid && k < 10) begin tick(); k++; end
    n_cmp++; if (out_byte !== 8'hFF) begin n_bad++; $display("FAIL wait_late_byte: got %h want ff", out_byte); end
    tick();
`endif
  endtask

  task automatic test_round_trip();
    logic [7:0] plain  [16];
    logic [7:0] cipher [16];
    logic [7:0] dec    [16];
    int         got;
    for (int i = 0; i < 16; i++) begin
      plain[i]  = 8'(i);
      cipher[i] = 8'h00;
      dec[i]    = 8'h00;
    end
    do_clear();
    gen_en = 1'b1;
    out_ready = 1'b1;
    run_stream(plain, cipher, got);
    n_cmp++; if (got !== 16) begin n_bad++; $display("FAIL rt_enc_count: got %0d want 16", got); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (cipher[i] !== (plain[i] ^ keys[i])) begin
        n_bad++;
        $display("FAIL rt_cipher[%0d]: got %h want %h", i, cipher[i], plain[i] ^ keys[i]);
      end
    end
    do_clear();
    run_stream(cipher, dec, got);
    n_cmp++; if (got !== 16) begin n_bad++; $display("FAIL rt_dec_count: got %0d want 16", got); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (dec[i] !== 8'(i)) begin n_bad++; $display("FAIL rt_plain[%0d]: got %h want %h", i, dec[i], 8'(i)); end
    end
  endtask

  task automatic test_reset_mid();
    int req0;
    do_clear();
    gen_en = 1'b1;
    out_ready = 1'b0;
    push_byte(8'h5C);
    push_byte(8'h5D);
    tick();
    nrst = 1'b0;
    gen_cd = 0;
    #1;
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rst_mid_count: got %0d want 0", fifo_count); end
    n_cmp++; if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL rst_mid_state: got %0d want %0d", dbg_state, S_IDLE); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    tick();
    nrst = 1'b1;
    req0 = n_req;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_idle: got busy=%b valid=%b want 0 0", busy, out_valid); end
    n_cmp++; if (n_req !== req0) begin n_bad++; $display("FAIL rst_mid_requests: got %0d want 0", n_req - req0); end
  endtask

  initial begin
    keys = '{8'h5A, 8'hC3, 8'h17, 8'hE8, 8'h3C, 8'h91, 8'h4D, 8'hA6,
             8'h72, 8'h0B, 8'hDE, 8'h65, 8'hB9, 8'h28, 8'hF4, 8'h8F};
    nrst            = 1'b0;
    clear           = 1'b0;
    in_byte         = 8'h00;
    in_valid        = 1'b0;
    out_ready       = 1'b0;
    hash_byte       = 8'h00;
    hash_byte_pulse = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_clear();
    test_timeout();
    test_round_trip();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stream_xor_unit.md
# stream_xor_unit

Byte-serial stream-cipher datapath sitting directly downstream of `hash_generator`. It buffers incoming plaintext or ciphertext bytes in a small FIFO and requests one keystream byte per buffered byte with a single-cycle pulse. It XORs the returned keystream byte with the FIFO head and presents the result on a valid/ready output port. Encryption and decryption are the same operation.

## Interface
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, ≥ 2.
- `TIMEOUT_CYCLES`, 64: WAIT_KEY cycles before a re-request; used only with the timeout feature.

Ports:
- `clk` in 1: single clock; all logic is on posedge.
- `nrst` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous flush of the FIFO, the FSM and `timeout_err`; also restarts the keystream.
- `in_byte` in 8: input data.
- `in_valid` in 1: input data valid.
- `in_ready` out 1: high when the FIFO is not full.
- `out_byte` out 8: XOR result.
- `out_valid` out 1: output data valid.
- `out_ready` in 1: downstream accepts the output.
- `request_hash_byte_pulse` out 1: one-cycle keystream request to `hash_generator`.
- `hash_byte` in 8: keystream byte; sampled only while `hash_byte_pulse` is high.
- `hash_byte_pulse` in 1: keystream byte is valid this cycle.
- `reset_hash` out 1: one-cycle pulse to the generator's `reset_hash` input.
- `busy` out 1: high when the FSM is not in S_IDLE or the FIFO is non-empty.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of FIFO entries occupied.
- `timeout_err` out 1: sticky flag, set when a keystream wait times out.

## Operation
- Reset values: `in_ready`=1; `out_byte`=0x00; `fifo_count`=0. All other outputs (`out_valid`, `request_hash_byte_pulse`, `reset_hash`, `busy`, `timeout_err`) are 0. FSM starts in S_IDLE.
- FIFO push occurs on `in_valid & in_ready`. A byte offered while full is not accepted, and the source holds it.
- FIFO pop occurs only on keystream capture. That requires a non-empty FIFO, so underflow is impossible.
- A push and pop in the same cycle both take effect and `fifo_count` is unchanged.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- FSM states:
  - S_IDLE: go to S_REQUEST when `fifo_count` ≠ 0.
  - S_REQUEST: `request_hash_byte_pulse` is a Moore decode of this state and is high for exactly one cycle. Next state is S_WAIT_KEY.
  - S_WAIT_KEY: on `hash_byte_pulse`, register `out_byte` = FIFO head ^ `hash_byte`, pop the FIFO, set `out_valid`, and go to S_OUTPUT.
  - S_OUTPUT: hold `out_byte`/`out_valid` stable until `out_ready`. On acceptance, clear `out_valid` and go to S_REQUEST if the FIFO is non-empty, otherwise S_IDLE.
- `hash_byte_pulse` outside S_WAIT_KEY is ignored.
- `clear` has priority over every other event in the same cycle:
  - FIFO is emptied and pointers are zeroed.
  - FSM goes to S_IDLE; `out_valid` and `timeout_err` are cleared.
  - `reset_hash` is registered high for the following cycle only.
  - A push in the same cycle as `clear` is discarded.
- Reset mid-transaction discards the FIFO contents and any pending keystream byte.

## Timing
- Minimum latency is 4 cycles from push to `out_valid`, with the generator at its best case (keystream byte 2 cycles after the request):
  - T0: push.
  - T1: S_REQUEST; pulse high.
  - T3: keystream capture.
  - T4: `out_valid` high.
- Sustained throughput is one byte per 4 cycles when `out_ready` is held high.
- Every request is followed by exactly one capture or one timeout; at most one request is outstanding.

## Configuration
- `STREAM_XOR_TIMEOUT_EN` defined:
  - A counter runs in S_WAIT_KEY.
  - After `TIMEOUT_CYCLES` cycles without `hash_byte_pulse`, `timeout_err` is set and the FSM returns to S_REQUEST to re-issue the request.
  - The counter clears on entering S_WAIT_KEY.
- `STREAM_XOR_TIMEOUT_EN` undefined: no counter is built, S_WAIT_KEY waits indefinitely, and `timeout_err` is tied to 0. The port list is identical in both builds.

## Structure
- `types_pkg` gains `stream_xor_state_t` (S_IDLE, S_REQUEST, S_WAIT_KEY, S_OUTPUT), alongside `hash_generator_state_t`.
- The FIFO is a sub-module, `byte_fifo`, parameterised by depth. It provides push/pop, head data and count, with the flush driven by `clear`.
- The FSM and XOR register live in `stream_xor_unit`.

## Test plan
- **Single byte:** push 0x41 with the model generator returning 0x5A two cycles after the request → `out_byte`=0x1B, `out_valid` at T4, exactly one request pulse.
- **Fill:** push 5 bytes back-to-back with `FIFO_DEPTH`=4 and `out_ready` low → `in_ready` drops after the 4th push and `fifo_count`=4. Raising `out_ready` drains all bytes in order, each XORed with its own keystream byte.
- **Backpressure:** hold `out_ready` low for 10 cycles in S_OUTPUT → `out_byte` stays stable and no further request pulse is issued.
- **Clear:** assert `clear` during S_WAIT_KEY with 3 bytes queued and a simultaneous push → `fifo_count`=0, S_IDLE, `reset_hash` high for exactly 1 cycle, later stray `hash_byte_pulse` ignored.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=8):** generator silent → `timeout_err`=1 after 8 cycles, second request pulse follows, a late 0xFF keystream byte with FIFO head 0x00 yields `out_byte`=0xFF.
- **Round trip:** XOR-encrypt bytes 0x00..0x0F, `clear`, then decrypt the 16 ciphertext bytes with the same key → original bytes 0x00..0x0F.
